// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_pkg
// Description : Shared types and constants for the serial command-frame
//               controller: FSM state encoding, command codes, default
//               frame start marker and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LOAD          = 8'h01;
    localparam logic [7:0] CMD_SET_MODE      = 8'h02;
    localparam logic [7:0] CMD_START         = 8'h03;
    localparam logic [7:0] CMD_SET_ADDR      = 8'h04;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_cmd_wr_port.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_wr_port
// Description : One-entry holding register in front of the pixel memory
//               write port. Captures a byte at the current write pointer,
//               holds request/address/data until accepted, drops bytes that
//               arrive while a request is still waiting (sticky overflow).
//               The pointer advances once per byte taken into the register,
//               so a pointer reload never disturbs a request in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmd_wr_port #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [7:0]        push_data_i,
    input  logic              ptr_load_i,
    input  logic [ADDR_W-1:0] ptr_value_i,
    input  logic              mem_wr_ready_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [7:0]        mem_wr_data_o,
    output logic              overflow_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        data_q,  data_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic              ovf_q,   ovf_d;
    logic              w_accept;
    logic              w_stalled;

    assign w_accept  = valid_q &  mem_wr_ready_i;
    assign w_stalled = valid_q & ~mem_wr_ready_i;

    // Next-state: retire on handshake, capture or drop new bytes, reload pointer.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        if (w_accept) begin
            valid_d = 1'b0;
        end
        if (push_i) begin
            if (w_stalled) begin
                ovf_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                addr_d  = ptr_q;
                data_d  = push_data_i;
                ptr_d   = ptr_q + ADDR_W'(1);
            end
        end
        if (ptr_load_i) begin
            ptr_d = ptr_value_i;
        end
    end

    // State register; reset drops any pending request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_wr_en_o   = valid_q;
    assign mem_wr_addr_o = addr_q;
    assign mem_wr_data_o = data_q;
    assign overflow_o    = ovf_q;

endmodule
`default_nettype wire

// File: rtl/serial_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_ctrl
// Description : Command-frame controller behind the serial byte receiver.
//               Frame: SYNC, CMD, LEN, payload[LEN], CHK. LOAD payload is
//               streamed to pixel memory; SET_MODE / SET_ADDR / START are
//               committed one cycle after the last frame byte.
//               Build option: define SERIAL_CMD_CHKSUM_EN to include the
//               trailing XOR checksum byte; otherwise frames end after the
//               payload (or after LEN when LEN is zero).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmd_ctrl
    import serial_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         ADDR_W         = 16,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic              clk_24_i,
    input  logic              reset_i,
    input  logic              rx_ready_i,
    input  logic [7:0]        rx_data_i,
    input  logic              mem_wr_ready_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [7:0]        mem_wr_data_o,
    output logic [7:0]        mode_o,
    output logic              start_proc_o,
    output logic              busy_o,
    output logic [7:0]        err_cnt_o,
    output logic              overflow_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef SERIAL_CMD_CHKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_COMMIT;
`endif

    logic             rx_ready_d_q;
    logic             w_strobe;
    state_t           state_q, state_d;
    logic [7:0]       cmd_q,   cmd_d;
    logic [7:0]       len_q,   len_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic [7:0]       b0_q,    b0_d;
    logic [7:0]       b1_q,    b1_d;
    logic [7:0]       mode_q,  mode_d;
    logic [7:0]       err_q,   err_d;
    logic             start_q, start_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    logic             w_chk_ok;
    logic             w_push;
    logic             w_ptr_load;
    logic [15:0]      w_addr_word;

`ifdef SERIAL_CMD_CHKSUM_EN
    logic [7:0]       chk_q,    chk_d;
    logic             chk_ok_q, chk_ok_d;
    assign w_chk_ok = chk_ok_q;
`else
    assign w_chk_ok = 1'b1;
`endif

    // One-cycle strobe per received byte from the receiver's level flag.
    assign w_strobe    = rx_ready_i & ~rx_ready_d_q;
    assign w_addr_word = {b0_q, b1_q};

    // Frame parser next-state, commit decisions and write-port requests.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        mode_d     = mode_q;
        err_d      = err_q;
        start_d    = 1'b0;
        w_push     = 1'b0;
        w_ptr_load = 1'b0;
`ifdef SERIAL_CMD_CHKSUM_EN
        chk_d      = chk_q;
        chk_ok_d   = chk_ok_q;
`endif
        tmo_d = ((state_q == ST_IDLE) || w_strobe) ? '0 : tmo_q + TMO_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (w_strobe && (rx_data_i == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_strobe) begin
                    cmd_d   = rx_data_i;
`ifdef SERIAL_CMD_CHKSUM_EN
                    chk_d   = rx_data_i;
`endif
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_strobe) begin
                    len_d   = rx_data_i;
                    cnt_d   = 8'd0;
`ifdef SERIAL_CMD_CHKSUM_EN
                    chk_d   = chk_q ^ rx_data_i;
`endif
                    state_d = (rx_data_i == 8'd0) ? ST_AFTER_DATA : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_strobe) begin
`ifdef SERIAL_CMD_CHKSUM_EN
                    chk_d = chk_q ^ rx_data_i;
`endif
                    if (cnt_q == 8'd0) b0_d = rx_data_i;
                    if (cnt_q == 8'd1) b1_d = rx_data_i;
                    w_push = (cmd_q == CMD_LOAD);
                    cnt_d  = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == len_q) begin
                        state_d = ST_AFTER_DATA;
                    end
                end
            end
`ifdef SERIAL_CMD_CHKSUM_EN
            ST_CHK: begin
                if (w_strobe) begin
                    chk_ok_d = (rx_data_i == chk_q);
                    state_d  = ST_COMMIT;
                end
            end
`endif
            ST_COMMIT: begin
                state_d = ST_IDLE;
                case (cmd_q)
                    CMD_LOAD: begin
                        if (!w_chk_ok) err_d = sat_inc8(err_q);
                    end
                    CMD_SET_MODE: begin
                        if (w_chk_ok && (len_q >= 8'd1)) mode_d = b0_q;
                        else                              err_d  = sat_inc8(err_q);
                    end
                    CMD_START: begin
                        if (w_chk_ok) start_d = 1'b1;
                        else          err_d   = sat_inc8(err_q);
                    end
                    CMD_SET_ADDR: begin
                        if (w_chk_ok && (len_q >= 8'd2)) w_ptr_load = 1'b1;
                        else                              err_d      = sat_inc8(err_q);
                    end
                    default: begin
                        err_d = sat_inc8(err_q);
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort a stalled frame; COMMIT always completes in its single cycle.
        if ((state_q != ST_IDLE) && (state_q != ST_COMMIT) && !w_strobe &&
            (tmo_q == TMO_LAST)) begin
            state_d = ST_IDLE;
            err_d   = sat_inc8(err_q);
        end
    end

    // Parser state register; the edge detector starts high so a level
    // already present at reset release is not mistaken for a new byte.
    always_ff @(posedge clk_24_i) begin
        if (reset_i) begin
            rx_ready_d_q <= 1'b1;
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            mode_q       <= '0;
            err_q        <= '0;
            start_q      <= 1'b0;
            tmo_q        <= '0;
`ifdef SERIAL_CMD_CHKSUM_EN
            chk_q        <= '0;
            chk_ok_q     <= 1'b0;
`endif
        end else begin
            rx_ready_d_q <= rx_ready_i;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            mode_q       <= mode_d;
            err_q        <= err_d;
            start_q      <= start_d;
            tmo_q        <= tmo_d;
`ifdef SERIAL_CMD_CHKSUM_EN
            chk_q        <= chk_d;
            chk_ok_q     <= chk_ok_d;
`endif
        end
    end

    serial_cmd_wr_port #(
        .ADDR_W (ADDR_W)
    ) u_wr_port (
        .clk_i          (clk_24_i),
        .reset_i        (reset_i),
        .push_i         (w_push),
        .push_data_i    (rx_data_i),
        .ptr_load_i     (w_ptr_load),
        .ptr_value_i    (ADDR_W'(w_addr_word)),
        .mem_wr_ready_i (mem_wr_ready_i),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .overflow_o     (overflow_o)
    );

    assign mode_o       = mode_q;
    assign start_proc_o = start_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign err_cnt_o    = err_q;

endmodule
`default_nettype wire
